// File: rtl/cm0_dap_dp_pwr_multi_if.sv
// rtl/cm0_dap_dp_pwr_multi_if.sv - signal bundle for the multi-domain DP power handshake block
//
// Purpose: groups the software request/ack, pin request/ack, DP/AP idle
// handshake and timeout error signals of cm0_dap_dp_pwr_multi.
// Parameter: NUM_DOM - number of power domains (must match the block).
// Modports:
//   slave  - the power controller block (drives *_o, samples *_i)
//   master - the surrounding system / testbench
interface cm0_dap_dp_pwr_multi_if #(
    parameter int NUM_DOM = 2
);
    logic [NUM_DOM-1:0] sw_pwrupreq_i;
    logic [NUM_DOM-1:0] sw_pwrupack_o;
    logic [NUM_DOM-1:0] pwrupreq_o;
    logic [NUM_DOM-1:0] pwrupack_i;
    logic               dp_req_dp_i;
    logic               ap_ack_dp_i;
    logic               reset_dp_ap_handshake_o;
    logic [NUM_DOM-1:0] timeout_err_o;
    logic               timeout_clr_i;

    modport slave (
        input  sw_pwrupreq_i, pwrupack_i, dp_req_dp_i, ap_ack_dp_i, timeout_clr_i,
        output sw_pwrupack_o, pwrupreq_o, reset_dp_ap_handshake_o, timeout_err_o
    );

    modport master (
        output sw_pwrupreq_i, pwrupack_i, dp_req_dp_i, ap_ack_dp_i, timeout_clr_i,
        input  sw_pwrupack_o, pwrupreq_o, reset_dp_ap_handshake_o, timeout_err_o
    );
endinterface

// File: rtl/cm0_dap_dp_pwr_multi.sv
// rtl/cm0_dap_dp_pwr_multi.sv - per-domain DP power-up/power-down 4-phase handshake controller
//
// Purpose: one independent FSM (OFF, PUP, ON, PDN_WAIT, PDN) per power domain
// drives a registered pin request and watches a synchronized pin ack. Domains
// selected by GATE_MASK only power down once the DP->AP handshake is idle.
// Optional macro: ARM_DAP_PWR_TIMEOUT_EN adds a per-domain saturating timeout
// counter over PUP/PDN and a sticky timeout error.
// Ports:
//   swclktck - only clock, rising edge
//   dpreset  - synchronous active-high reset
//   pwr      - cm0_dap_dp_pwr_multi_if.slave: sw_pwrupreq_i/sw_pwrupack_o,
//              pwrupreq_o/pwrupack_i (async), dp_req_dp_i, ap_ack_dp_i,
//              reset_dp_ap_handshake_o, timeout_err_o, timeout_clr_i
module cm0_dap_dp_pwr_multi #(
    parameter int                 NUM_DOM     = 2,
    parameter int                 SYNC_STAGES = 2,
    parameter logic [NUM_DOM-1:0] GATE_MASK   = NUM_DOM'(1),
    parameter int                 TO_W        = 8
) (
    input  logic                          swclktck,
    input  logic                          dpreset,
    cm0_dap_dp_pwr_multi_if.slave         pwr
);
    typedef enum logic [2:0] {
        ST_OFF,
        ST_PUP,
        ST_ON,
        ST_PDN_WAIT,
        ST_PDN
    } state_t;

    state_t                 state_q [NUM_DOM];
    state_t                 state_d [NUM_DOM];
    logic [SYNC_STAGES-1:0] sync_q  [NUM_DOM];
    logic [NUM_DOM-1:0]     ack_s;
    logic [NUM_DOM-1:0]     req_q, req_d;
    logic [NUM_DOM-1:0]     on_q, on_d;
    logic [NUM_DOM-1:0]     pdn_wait_gated;
    logic [1:0]             fill_q;
    logic                   sync_valid;
    logic                   ap_idle;

    // The synchronizer is cleared by reset, so for SYNC_STAGES cycles after
    // reset ack_s does not reflect the pin. OFF->PUP is held off until the
    // pipeline has refilled and shows the pin ack low, so a reset during a
    // live handshake cannot start a new request against a still-high ack.
    assign sync_valid = (fill_q == 2'(SYNC_STAGES));
    assign ap_idle    = !pwr.dp_req_dp_i && !pwr.ap_ack_dp_i;

    always_comb begin
        ack_s = '0;
        for (int i = 0; i < NUM_DOM; i++) begin
            ack_s[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    always_ff @(posedge swclktck) begin
        if (dpreset) begin
            fill_q <= '0;
            req_q  <= '0;
            on_q   <= '0;
            for (int i = 0; i < NUM_DOM; i++) begin
                state_q[i] <= ST_OFF;
                sync_q[i]  <= '0;
            end
        end else begin
            if (!sync_valid) begin
                fill_q <= fill_q + 2'd1;
            end
            req_q <= req_d;
            on_q  <= on_d;
            for (int i = 0; i < NUM_DOM; i++) begin
                state_q[i] <= state_d[i];
                sync_q[i]  <= {sync_q[i][SYNC_STAGES-2:0], pwr.pwrupack_i[i]};
            end
        end
    end

    always_comb begin
        pdn_wait_gated = '0;
        req_d          = '0;
        on_d           = '0;
        for (int i = 0; i < NUM_DOM; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                ST_OFF:      if (pwr.sw_pwrupreq_i[i] && !ack_s[i] && sync_valid) state_d[i] = ST_PUP;
                ST_PUP:      if (ack_s[i]) state_d[i] = ST_ON;
                ST_ON:       if (!pwr.sw_pwrupreq_i[i]) state_d[i] = ST_PDN_WAIT;
                ST_PDN_WAIT: begin
                    // A renewed request cancels before the idle exit is considered.
                    if (pwr.sw_pwrupreq_i[i]) begin
                        state_d[i] = ST_ON;
                    end else if (!GATE_MASK[i] || ap_idle) begin
                        state_d[i] = ST_PDN;
                    end
                    pdn_wait_gated[i] = GATE_MASK[i];
                end
                ST_PDN:      if (!ack_s[i]) state_d[i] = ST_OFF;
                default:     state_d[i] = ST_OFF;
            endcase
            // Registered from next state so the pin request moves with the FSM.
            req_d[i] = (state_d[i] == ST_PUP) || (state_d[i] == ST_ON) ||
                       (state_d[i] == ST_PDN_WAIT);
            on_d[i]  = (state_d[i] == ST_ON);
        end
    end

    assign pwr.pwrupreq_o              = req_q;
    assign pwr.sw_pwrupack_o           = on_q;
    assign pwr.reset_dp_ap_handshake_o = pwr.dp_req_dp_i && pwr.ap_ack_dp_i && (|pdn_wait_gated);

`ifdef ARM_DAP_PWR_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_MAX    = '1;
    localparam logic [TO_W-1:0] TO_SET_AT = TO_MAX - TO_W'(1);

    logic [TO_W-1:0]    to_cnt_q [NUM_DOM];
    logic [NUM_DOM-1:0] to_err_q;
    logic [NUM_DOM-1:0] to_phase;
    logic [NUM_DOM-1:0] to_entry;
    logic [NUM_DOM-1:0] to_set;

    // The error fires only on the step into saturation, so a clear while the
    // counter is parked at its maximum is not immediately undone.
    always_comb begin
        to_phase = '0;
        to_entry = '0;
        to_set   = '0;
        for (int i = 0; i < NUM_DOM; i++) begin
            to_phase[i] = (state_d[i] == ST_PUP) || (state_d[i] == ST_PDN);
            to_entry[i] = to_phase[i] && (state_d[i] != state_q[i]);
            to_set[i]   = to_phase[i] && !to_entry[i] && (to_cnt_q[i] == TO_SET_AT);
        end
    end

    always_ff @(posedge swclktck) begin
        if (dpreset) begin
            to_err_q <= '0;
            for (int i = 0; i < NUM_DOM; i++) begin
                to_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_DOM; i++) begin
                if (to_entry[i]) begin
                    to_cnt_q[i] <= '0;
                end else if (to_phase[i] && (to_cnt_q[i] != TO_MAX)) begin
                    to_cnt_q[i] <= to_cnt_q[i] + TO_W'(1);
                end
            end
            to_err_q <= to_set | (to_err_q & ~{NUM_DOM{pwr.timeout_clr_i}});
        end
    end

    assign pwr.timeout_err_o = to_err_q;
`else
    logic            unused_clr;
    logic [TO_W-1:0] unused_to_w;

    assign unused_clr        = pwr.timeout_clr_i;
    assign unused_to_w       = '0;
    assign pwr.timeout_err_o = '0;
`endif
endmodule
